// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//
// Circular reorder buffer that sits after the reservation station. The
// decoder allocates one entry per issued instruction, the RS write-back bus
// marks entries complete, and completed entries retire in program order to
// the register file. Branch mispredictions and jalr redirects are resolved
// at retire time and produce a one-cycle flush with a fetch redirect PC.
//
// Ports
//   clk_in, rst_in, rdy_in      clock, sync active-high reset, global enable
//   issue_*                     allocation request from the decoder
//   rob_full, rob_tail          occupancy / next allocated index (comb)
//   wb_*                        result write-back from the RS
//   qry_{j,k}_id/ready/value    operand lookup with write-back forwarding
//   commit_*                    registered retire pulse toward the regfile
//   flush, redirect_pc          registered pipeline-flush pulse and new PC
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_WIDTH     = 8,
    parameter int ROB_WIDTH_BIT = 3,
    parameter int REG_ID_BIT    = 5
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     issue_valid,
    input  logic [1:0]               issue_type,
    input  logic [REG_ID_BIT-1:0]    issue_rd,
    input  logic [31:0]              issue_pc,
    input  logic [31:0]              issue_target,
    input  logic                     issue_pred,
    output logic                     rob_full,
    output logic [ROB_WIDTH_BIT-1:0] rob_tail,
    input  logic                     wb_valid,
    input  logic [ROB_WIDTH_BIT-1:0] wb_rob_id,
    input  logic [31:0]              wb_value,
    input  logic [31:0]              wb_new_pc,
    input  logic [ROB_WIDTH_BIT-1:0] qry_j_id,
    input  logic [ROB_WIDTH_BIT-1:0] qry_k_id,
    output logic                     qry_j_ready,
    output logic                     qry_k_ready,
    output logic [31:0]              qry_j_value,
    output logic [31:0]              qry_k_value,
    output logic                     commit_valid,
    output logic [ROB_WIDTH_BIT-1:0] commit_rob_id,
    output logic [REG_ID_BIT-1:0]    commit_rd,
    output logic [31:0]              commit_value,
    output logic                     flush,
    output logic [31:0]              redirect_pc
);

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_BRANCH = 2'd1,
        TYPE_JALR   = 2'd2,
        TYPE_NONE   = 2'd3
    } entry_type_e;

    localparam logic [ROB_WIDTH_BIT:0] FULL_COUNT = (ROB_WIDTH_BIT+1)'(ROB_WIDTH);

    // Control state
    logic [ROB_WIDTH_BIT-1:0] head;
    logic [ROB_WIDTH_BIT-1:0] tail;
    logic [ROB_WIDTH_BIT:0]   count;
    logic [ROB_WIDTH-1:0]     busy;
    logic [ROB_WIDTH-1:0]     ready;

    // Entry payload
    entry_type_e           ent_type   [ROB_WIDTH];
    logic [REG_ID_BIT-1:0] ent_rd     [ROB_WIDTH];
    logic [31:0]           ent_pc     [ROB_WIDTH];
    logic [31:0]           ent_target [ROB_WIDTH];
    logic [31:0]           ent_value  [ROB_WIDTH];
    logic [31:0]           ent_new_pc [ROB_WIDTH];
    logic [ROB_WIDTH-1:0]  ent_pred;

    logic        head_commit;
    logic        head_taken;
    logic        head_mispredict;
    logic        head_jalr;
    logic        commit_flush;
    logic        do_issue;
    logic        do_wb;
    logic [31:0] redirect_next;

    assign rob_full = (count == FULL_COUNT);
    assign rob_tail = tail;

    // Retire decision is made from registered state only.
    assign head_commit     = busy[head] && ready[head];
    assign head_taken      = ent_value[head][0];
    assign head_mispredict = (ent_type[head] == TYPE_BRANCH) && (head_taken != ent_pred[head]);
    assign head_jalr       = (ent_type[head] == TYPE_JALR);
    assign commit_flush    = head_commit && (head_mispredict || head_jalr);
    assign redirect_next   = head_jalr  ? ent_new_pc[head] :
                             head_taken ? ent_target[head] : ent_pc[head] + 32'd4;

    // A flushing edge discards the same-cycle issue and write-back. The tail
    // entry is never busy unless the buffer is full, so issue and write-back
    // can never target the same entry.
    assign do_issue = !rst_in && rdy_in && !commit_flush && issue_valid && !rob_full;
    assign do_wb    = !rst_in && rdy_in && !commit_flush && wb_valid && busy[wb_rob_id];

    // Operand lookup, forwarding a result that is on the write-back bus now.
    always_comb begin
        // NOTE: every output gets a default before the conditionals so no
        // path leaves it unassigned, which would otherwise infer a latch.
        qry_j_ready = 1'b0;
        qry_j_value = ent_value[qry_j_id];
        qry_k_ready = 1'b0;
        qry_k_value = ent_value[qry_k_id];
        if (busy[qry_j_id]) begin
            if (wb_valid && wb_rob_id == qry_j_id) begin
                qry_j_ready = 1'b1;
                qry_j_value = wb_value;
            end else begin
                qry_j_ready = ready[qry_j_id];
            end
        end
        if (busy[qry_k_id]) begin
            if (wb_valid && wb_rob_id == qry_k_id) begin
                qry_k_ready = 1'b1;
                qry_k_value = wb_value;
            end else begin
                qry_k_ready = ready[qry_k_id];
            end
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // right-hand side sees pre-edge values; later writes to the same bit
        // in this block win (commit clearing ready overrides a write-back).
        if (rst_in) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            busy          <= '0;
            ready         <= '0;
            commit_valid  <= 1'b0;
            commit_rob_id <= '0;
            commit_rd     <= '0;
            commit_value  <= '0;
            flush         <= 1'b0;
            redirect_pc   <= '0;
        end else if (!rdy_in) begin
            commit_valid <= 1'b0;
            flush        <= 1'b0;
        end else begin
            commit_valid <= head_commit;
            flush        <= commit_flush;
            if (head_commit) begin
                commit_rob_id <= head;
                commit_value  <= ent_value[head];
                commit_rd     <= (ent_type[head] == TYPE_REG || ent_type[head] == TYPE_JALR)
                                 ? ent_rd[head] : '0;
            end
            if (commit_flush) begin
                redirect_pc <= redirect_next;
                head        <= '0;
                tail        <= '0;
                count       <= '0;
                busy        <= '0;
                ready       <= '0;
            end else begin
                if (do_wb) begin
                    ready[wb_rob_id] <= 1'b1;
                end
                if (do_issue) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + ROB_WIDTH_BIT'(1);
                end
                if (head_commit) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= head + ROB_WIDTH_BIT'(1);
                end
                case ({do_issue, head_commit})
                    2'b10:   count <= count + (ROB_WIDTH_BIT+1)'(1);
                    2'b01:   count <= count - (ROB_WIDTH_BIT+1)'(1);
                    default: ;
                endcase
            end
        end
    end

    // Payload storage.
    // NOTE: payload arrays have no reset; their contents are only looked at
    // while the matching busy/ready bit is set, and those bits are reset.
    always_ff @(posedge clk_in) begin
        if (do_issue) begin
            ent_type[tail]   <= entry_type_e'(issue_type);
            ent_rd[tail]     <= issue_rd;
            ent_pc[tail]     <= issue_pc;
            ent_target[tail] <= issue_target;
            ent_pred[tail]   <= issue_pred;
        end
        if (do_wb) begin
            ent_value[wb_rob_id]  <= wb_value;
            ent_new_pc[wb_rob_id] <= wb_new_pc;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// ---------------------------------------------------------------------------
// tb_reorder_buffer
//
// Self-checking bench for reorder_buffer. A queue-based reference model of
// the buffer (program-ordered list of live entry ids plus per-id payload)
// predicts the combinational outputs before every edge and the registered
// commit/flush outputs after it. Directed scenarios come first, followed by
// a randomized run.
// ---------------------------------------------------------------------------
module tb_reorder_buffer;

    localparam int W = 8;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        issue_valid = 1'b0;
    logic [1:0]  issue_type = '0;
    logic [4:0]  issue_rd = '0;
    logic [31:0] issue_pc = '0;
    logic [31:0] issue_target = '0;
    logic        issue_pred = 1'b0;
    logic        rob_full;
    logic [2:0]  rob_tail;
    logic        wb_valid = 1'b0;
    logic [2:0]  wb_rob_id = '0;
    logic [31:0] wb_value = '0;
    logic [31:0] wb_new_pc = '0;
    logic [2:0]  qry_j_id = '0;
    logic [2:0]  qry_k_id = '0;
    logic        qry_j_ready, qry_k_ready;
    logic [31:0] qry_j_value, qry_k_value;
    logic        commit_valid;
    logic [2:0]  commit_rob_id;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic        flush;
    logic [31:0] redirect_pc;

    always #5 clk_in = ~clk_in;

    reorder_buffer dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .issue_valid   (issue_valid),
        .issue_type    (issue_type),
        .issue_rd      (issue_rd),
        .issue_pc      (issue_pc),
        .issue_target  (issue_target),
        .issue_pred    (issue_pred),
        .rob_full      (rob_full),
        .rob_tail      (rob_tail),
        .wb_valid      (wb_valid),
        .wb_rob_id     (wb_rob_id),
        .wb_value      (wb_value),
        .wb_new_pc     (wb_new_pc),
        .qry_j_id      (qry_j_id),
        .qry_k_id      (qry_k_id),
        .qry_j_ready   (qry_j_ready),
        .qry_k_ready   (qry_k_ready),
        .qry_j_value   (qry_j_value),
        .qry_k_value   (qry_k_value),
        .commit_valid  (commit_valid),
        .commit_rob_id (commit_rob_id),
        .commit_rd     (commit_rd),
        .commit_value  (commit_value),
        .flush         (flush),
        .redirect_pc   (redirect_pc)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          q[$];          // live entry ids, oldest first
    int          m_tail;
    logic        m_busy  [W];
    logic        m_ready [W];
    logic [1:0]  m_type  [W];
    logic [4:0]  m_rd    [W];
    logic [31:0] m_pc    [W];
    logic [31:0] m_tgt   [W];
    logic        m_pred  [W];
    logic [31:0] m_val   [W];
    logic [31:0] m_npc   [W];

    logic        e_cv, e_fl;
    logic [2:0]  e_id;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_rpc;

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        for (int i = 0; i < W; i++) begin
            m_busy[i]  = 1'b0;
            m_ready[i] = 1'b0;
        end
        e_cv = 0; e_fl = 0; e_id = 0; e_rd = 0; e_val = 0; e_rpc = 0;
    endtask

    function automatic void qexp(input logic [2:0] id, output logic r, output logic [31:0] v);
        logic fwd;
        fwd = wb_valid && (wb_rob_id == id) && m_busy[id];
        r   = (m_busy[id] && m_ready[id]) || fwd;
        v   = fwd ? wb_value : m_val[id];
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit com;
        int h;
        if (rst_in) begin
            model_reset();
            return;
        end
        if (!rdy_in) begin
            e_cv = 0;
            e_fl = 0;
            return;
        end
        com  = (q.size() > 0) && m_ready[q[0]];
        h    = (q.size() > 0) ? q[0] : 0;
        e_cv = com;
        e_fl = 0;
        if (com) begin
            e_id  = 3'(h);
            e_val = m_val[h];
            e_rd  = (m_type[h] == 2'd0 || m_type[h] == 2'd2) ? m_rd[h] : 5'd0;
            if (m_type[h] == 2'd1 && m_val[h][0] != m_pred[h]) begin
                e_fl  = 1;
                e_rpc = m_val[h][0] ? m_tgt[h] : m_pc[h] + 32'd4;
            end
            if (m_type[h] == 2'd2) begin
                e_fl  = 1;
                e_rpc = m_npc[h];
            end
        end
        if (e_fl) begin
            q.delete();
            m_tail = 0;
            for (int i = 0; i < W; i++) begin
                m_busy[i]  = 1'b0;
                m_ready[i] = 1'b0;
            end
        end else begin
            bit full;
            full = (q.size() == W);
            if (wb_valid && m_busy[wb_rob_id]) begin
                m_ready[wb_rob_id] = 1'b1;
                m_val[wb_rob_id]   = wb_value;
                m_npc[wb_rob_id]   = wb_new_pc;
            end
            if (issue_valid && !full) begin
                m_busy[m_tail]  = 1'b1;
                m_ready[m_tail] = 1'b0;
                m_type[m_tail]  = issue_type;
                m_rd[m_tail]    = issue_rd;
                m_pc[m_tail]    = issue_pc;
                m_tgt[m_tail]   = issue_target;
                m_pred[m_tail]  = issue_pred;
                q.push_back(m_tail);
                m_tail = (m_tail + 1) % W;
            end
            if (com) begin
                void'(q.pop_front());
                m_busy[h]  = 1'b0;
                m_ready[h] = 1'b0;
            end
        end
    endtask

    // One clock: check combinational outputs, step model, check registered ones.
    task automatic tick();
        logic        r;
        logic [31:0] v;
        #1;
        check("rob_full", 32'(rob_full), 32'(q.size() == W));
        check("rob_tail", 32'(rob_tail), m_tail);
        qexp(qry_j_id, r, v);
        check("qry_j_ready", 32'(qry_j_ready), 32'(r));
        if (r) check("qry_j_value", qry_j_value, v);
        qexp(qry_k_id, r, v);
        check("qry_k_ready", 32'(qry_k_ready), 32'(r));
        if (r) check("qry_k_value", qry_k_value, v);
        model_step();
        @(posedge clk_in);
        #1;
        check("commit_valid", 32'(commit_valid), 32'(e_cv));
        check("flush", 32'(flush), 32'(e_fl));
        if (e_cv) begin
            check("commit_rob_id", 32'(commit_rob_id), 32'(e_id));
            check("commit_rd", 32'(commit_rd), 32'(e_rd));
            check("commit_value", commit_value, e_val);
        end
        if (e_fl) check("redirect_pc", redirect_pc, e_rpc);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic do_issue(input logic [1:0] t, input logic [4:0] rd,
                            input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
        issue_valid = 1'b1; issue_type = t; issue_rd = rd;
        issue_pc = pc; issue_target = tgt; issue_pred = pred;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic do_wb(input logic [2:0] id, input logic [31:0] val, input logic [31:0] npc);
        wb_valid = 1'b1; wb_rob_id = id; wb_value = val; wb_new_pc = npc;
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        // Bring the DUT out of an unknown state before the model starts checking.
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        model_reset();
        do_reset();
        check("rst_commit_rob_id", 32'(commit_rob_id), 32'd0);
        check("rst_commit_rd", 32'(commit_rd), 32'd0);
        check("rst_commit_value", commit_value, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        check("rst_rob_tail", 32'(rob_tail), 32'd0);

        // In-order retire of out-of-order completions.
        do_issue(2'd0, 5'd1, 32'h10, 32'h0, 1'b0);
        do_issue(2'd0, 5'd2, 32'h14, 32'h0, 1'b0);
        do_issue(2'd0, 5'd3, 32'h18, 32'h0, 1'b0);
        do_wb(3'd2, 32'h11, 32'h0);
        do_wb(3'd0, 32'h22, 32'h0);
        do_wb(3'd1, 32'h33, 32'h0);
        check("ord0_valid", 32'(commit_valid), 32'd1);
        check("ord0_value", commit_value, 32'h22);
        check("ord0_rd", 32'(commit_rd), 32'd1);
        tick();
        check("ord1_value", commit_value, 32'h33);
        check("ord1_id", 32'(commit_rob_id), 32'd1);
        tick();
        check("ord2_value", commit_value, 32'h11);
        check("ord2_id", 32'(commit_rob_id), 32'd2);
        tick();
        check("ord_idle", 32'(commit_valid), 32'd0);

        // Fill to capacity, drop the overflow issue, then commit+issue at count 7.
        do_reset();
        for (int i = 0; i < W; i++) do_issue(2'd0, 5'(i + 1), 32'h1000 + 32'(4 * i), 32'h0, 1'b0);
        check("fill_full", 32'(rob_full), 32'd1);
        check("fill_tail_wrap", 32'(rob_tail), 32'd0);
        do_issue(2'd0, 5'd9, 32'h2000, 32'h0, 1'b0);
        check("drop_tail", 32'(rob_tail), 32'd0);
        do_wb(3'd0, 32'ha0, 32'h0);
        tick();
        check("fill_commit0", 32'(commit_valid), 32'd1);
        check("fill_not_full", 32'(rob_full), 32'd0);
        do_wb(3'd1, 32'ha1, 32'h0);
        do_issue(2'd0, 5'd10, 32'h2004, 32'h0, 1'b0);
        check("both_commit", 32'(commit_valid), 32'd1);
        check("both_tail", 32'(rob_tail), 32'd1);
        check("both_not_full", 32'(rob_full), 32'd0);
        do_issue(2'd0, 5'd11, 32'h2008, 32'h0, 1'b0);
        check("refull", 32'(rob_full), 32'd1);

        // Mispredicted not-taken branch flushes younger work.
        do_reset();
        do_issue(2'd1, 5'd5, 32'h100, 32'h200, 1'b0);
        do_issue(2'd0, 5'd7, 32'h104, 32'h0, 1'b0);
        do_wb(3'd0, 32'h1, 32'h0);
        tick();
        check("br_flush", 32'(flush), 32'd1);
        check("br_redirect", redirect_pc, 32'h200);
        check("br_rd", 32'(commit_rd), 32'd0);
        check("br_tail", 32'(rob_tail), 32'd0);
        check("br_empty", 32'(rob_full), 32'd0);
        do_wb(3'd1, 32'h77, 32'h0);

        // Correct prediction, then a taken-predicted branch that falls through.
        do_issue(2'd1, 5'd0, 32'h80, 32'h90, 1'b1);
        do_wb(3'd0, 32'h1, 32'h0);
        tick();
        check("br_ok_commit", 32'(commit_valid), 32'd1);
        check("br_ok_noflush", 32'(flush), 32'd0);
        do_issue(2'd1, 5'd0, 32'h40, 32'h60, 1'b1);
        do_wb(3'd1, 32'h0, 32'h0);
        tick();
        check("br_nt_flush", 32'(flush), 32'd1);
        check("br_nt_redirect", redirect_pc, 32'h44);

        // jalr always redirects and still writes its link register.
        do_issue(2'd2, 5'd1, 32'h50, 32'h0, 1'b0);
        do_wb(3'd0, 32'h104, 32'h300);
        tick();
        check("jalr_rd", 32'(commit_rd), 32'd1);
        check("jalr_value", commit_value, 32'h104);
        check("jalr_flush", 32'(flush), 32'd1);
        check("jalr_redirect", redirect_pc, 32'h300);

        // Same-cycle forwarding on the query ports.
        for (int i = 0; i < 4; i++) do_issue(2'd0, 5'(i + 1), 32'h400 + 32'(4 * i), 32'h0, 1'b0);
        qry_j_id = 3'd3; qry_k_id = 3'd5;
        wb_valid = 1'b1; wb_rob_id = 3'd3; wb_value = 32'hdead; wb_new_pc = 32'h0;
        #1;
        check("fwd_ready", 32'(qry_j_ready), 32'd1);
        check("fwd_value", qry_j_value, 32'hdead);
        check("idle_entry_ready", 32'(qry_k_ready), 32'd0);
        tick();
        wb_valid = 1'b0;

        // Global stall holds a ready head.
        do_wb(3'd0, 32'h55, 32'h0);
        rdy_in = 1'b0;
        tick();
        check("stall1", 32'(commit_valid), 32'd0);
        tick();
        check("stall2", 32'(commit_valid), 32'd0);
        rdy_in = 1'b1;
        tick();
        check("unstall_valid", 32'(commit_valid), 32'd1);
        check("unstall_value", commit_value, 32'h55);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            int t;
            rst_in      = ($urandom_range(0, 299) == 0);
            rdy_in      = ($urandom_range(0, 7) != 0);
            issue_valid = ($urandom_range(0, 1) == 1);
            t           = $urandom_range(0, 7);
            issue_type  = (t < 4) ? 2'd0 : (t == 4) ? 2'd1 : (t == 5) ? 2'd2 : 2'd3;
            issue_rd    = 5'($urandom_range(0, 31));
            issue_pc    = $urandom & 32'hffff_fffc;
            issue_target = $urandom & 32'hffff_fffc;
            issue_pred  = 1'($urandom_range(0, 1));
            wb_valid    = ($urandom_range(0, 2) != 0);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                wb_rob_id = 3'(q[$urandom_range(0, q.size() - 1)]);
            else
                wb_rob_id = 3'($urandom_range(0, W - 1));
            wb_value    = $urandom;
            wb_new_pc   = $urandom & 32'hffff_fffc;
            qry_j_id    = 3'($urandom_range(0, W - 1));
            qry_k_id    = 3'($urandom_range(0, W - 1));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
